// File: rtl/line_ahb_pkg.sv
// line_ahb_pkg: AHB-Lite encodings and state codes shared by line_ahb_master and its bench
package line_ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000, HBURST_INCR4 = 3'b011, HSIZE_WORD = 3'b010;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0, S_ADDR0 = 3'd1, S_PIPE = 3'd2, S_LAST = 3'd3, S_DONE = 3'd4, S_ERR1 = 3'd5;
endpackage

// File: rtl/line_ahb_master_if.sv
// line_ahb_master_if: AHB-Lite master port bundle (address/control/write data out, read data/ready/resp in)
interface line_ahb_master_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  modport master(output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
                 input HRDATA, HREADY, HRESP);
  modport slave(input HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
                output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/line_ahb_master.sv
// line_ahb_master: issues one 128-bit line read/write as four 32-bit AHB-Lite beats
//   HCLK/HRESETn: clock, async active-low reset
//   mem_req/mem_write/mem_addr/mem_wdata in; mem_rdata/mem_valid/mem_error out (line side)
//   ahb: AHB-Lite master port
//   LINE_AHB_MASTER_BURST_EN defined: pipelined INCR4 burst; undefined: four unpipelined NONSEQ SINGLE beats
module line_ahb_master
  import line_ahb_pkg::*;
#(
  parameter int          ADDR_BITS = 16,
  parameter logic [31:0] BASE_ADDR = 32'h1c000000,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 mem_req,
  input  logic                 mem_write,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic [127:0]         mem_wdata,
  output logic [127:0]         mem_rdata,
  output logic                 mem_valid,
  output logic                 mem_error,
  line_ahb_master_if.master    ahb
);
`ifdef LINE_AHB_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  state_t       state_q, state_d;
  logic [1:0]   abeat_q, abeat_d, dbeat_q, dbeat_d;
  logic [31:0]  haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic         hwrite_q, hwrite_d, err_q, err_d;
  logic [127:0] wdata_q, wdata_d, rdata_q, rdata_d;
  // PIPE: address beat abeat_q and data beat dbeat_q in flight together (burst only).
  // LAST: data phase only; in single mode it returns to ADDR0 for the next beat.
  always_comb begin
    state_d  = state_q;
    abeat_d  = abeat_q;
    dbeat_d  = dbeat_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    hwrite_d = hwrite_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: if (mem_req) begin
        state_d  = S_ADDR0;
        abeat_d  = 2'd0;
        dbeat_d  = 2'd0;
        haddr_d  = BASE_ADDR + 32'({mem_addr, 4'b0000});
        hwrite_d = mem_write;
        wdata_d  = mem_wdata;
        rdata_d  = '0;
        err_d    = 1'b0;
      end
      S_ADDR0: if (ahb.HREADY) begin
        state_d  = BURST ? S_PIPE : S_LAST;
        dbeat_d  = abeat_q;
        hwdata_d = wdata_q[{abeat_q, 5'b0} +: 32];
        if (BURST) begin
          abeat_d = abeat_q + 2'd1;
          haddr_d = haddr_q + 32'd4;
        end
      end
      S_PIPE, S_LAST: if (ahb.HRESP) begin
        state_d = ahb.HREADY ? S_DONE : S_ERR1;
        err_d   = 1'b1;
      end else if (ahb.HREADY) begin
        if (!hwrite_q) rdata_d[{dbeat_q, 5'b0} +: 32] = ahb.HRDATA;
        if (state_q == S_PIPE) begin
          dbeat_d  = abeat_q;
          hwdata_d = wdata_q[{abeat_q, 5'b0} +: 32];
          if (abeat_q == 2'd3) state_d = S_LAST;
          else begin
            abeat_d = abeat_q + 2'd1;
            haddr_d = haddr_q + 32'd4;
          end
        end else if (dbeat_q == 2'd3) state_d = S_DONE;
        else begin
          state_d = S_ADDR0;
          abeat_d = abeat_q + 2'd1;
          haddr_d = haddr_q + 32'd4;
        end
      end
      S_ERR1: state_d = ahb.HREADY ? S_DONE : S_ERR1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      abeat_q  <= '0;
      dbeat_q  <= '0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      hwrite_q <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      abeat_q  <= abeat_d;
      dbeat_q  <= dbeat_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      hwrite_q <= hwrite_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  // An ERROR response drops the pending SEQ beat combinationally in its first cycle.
  assign ahb.HTRANS    = state_q == S_ADDR0 ? HTRANS_NONSEQ :
                         (state_q == S_PIPE && !ahb.HRESP) ? HTRANS_SEQ : HTRANS_IDLE;
  assign ahb.HBURST    = (BURST && (state_q == S_ADDR0 || state_q == S_PIPE)) ? HBURST_INCR4 : HBURST_SINGLE;
  assign ahb.HADDR     = haddr_q;
  assign ahb.HWRITE    = hwrite_q;
  assign ahb.HSIZE     = HSIZE_WORD;
  assign ahb.HPROT     = HPROT_VAL;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HWDATA    = hwdata_q;
  assign mem_valid     = state_q == S_DONE;
  assign mem_error     = mem_valid && err_q;
  assign mem_rdata     = rdata_q;
endmodule

// File: tb/tb_line_ahb_master.sv
// tb_line_ahb_master: randomized self-checking bench with a reactive AHB slave and a line-level reference model
module tb_line_ahb_master;
  import line_ahb_pkg::*;
`ifdef LINE_AHB_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h1c000000;
  logic         HCLK = 1'b0, HRESETn = 1'b0;
  logic         mem_req = 1'b0, mem_write = 1'b0;
  logic [15:0]  mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic         mem_valid, mem_error;
  line_ahb_master_if ahb();
  line_ahb_master #(.ADDR_BITS(16), .BASE_ADDR(BASE), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_error(mem_error), .ahb(ahb));
  always #5 HCLK = ~HCLK;
  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  logic [15:0]  p_line;
  bit           p_write;
  logic [127:0] p_wdata;
  logic [31:0]  p_rd[4];
  int           p_wait[4];
  int           p_err;
  int  acnt, dbeat, dp_wait;
  bit  dp, dp_err_stage, killed, prev_hold;
  logic [31:0] prev_addr;
  logic [1:0]  prev_trans;
  initial begin
    ahb.HREADY = 1'b1;
    ahb.HRESP  = 1'b0;
    ahb.HRDATA = '0;
    dp = 0;
    prev_hold = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp = 0;
        prev_hold = 0;
        ahb.HREADY = 1'b1;
        ahb.HRESP = 1'b0;
        continue;
      end
      ahb.HRDATA = $urandom;
      if (dp && dbeat == p_err) begin
        ahb.HRESP = 1'b1;
        ahb.HREADY = dp_err_stage;
        dp_err_stage = 1'b1;
      end else if (dp && dp_wait > 0) begin
        ahb.HRESP = 1'b0;
        ahb.HREADY = 1'b0;
        dp_wait--;
      end else begin
        ahb.HRESP = 1'b0;
        ahb.HREADY = 1'b1;
        if (dp) ahb.HRDATA = p_rd[dbeat];
      end
      #1;
      if (dp && ahb.HRESP && !ahb.HREADY) check("err_cycle1_htrans", ahb.HTRANS, HTRANS_IDLE);
      if (prev_hold && !ahb.HRESP) begin
        check("hold_haddr", ahb.HADDR, prev_addr);
        check("hold_htrans", ahb.HTRANS, prev_trans);
      end
      prev_hold  = !ahb.HREADY && ahb.HTRANS != HTRANS_IDLE;
      prev_addr  = ahb.HADDR;
      prev_trans = ahb.HTRANS;
      if (ahb.HREADY) begin
        automatic bit was = dp;
        if (dp) begin
          if (p_write && !ahb.HRESP) check("hwdata", ahb.HWDATA, p_wdata[32*dbeat +: 32]);
          if (ahb.HRESP) killed = 1;
          dp = 0;
        end
        if (ahb.HTRANS != HTRANS_IDLE) begin
          check("extra_beat", killed || acnt > 3, 0);
          check("haddr", ahb.HADDR, BASE + 32'({p_line, 4'b0000}) + 32'(4 * acnt));
          check("htrans", ahb.HTRANS, (acnt == 0 || !BURST) ? HTRANS_NONSEQ : HTRANS_SEQ);
          check("hburst", ahb.HBURST, BURST ? HBURST_INCR4 : HBURST_SINGLE);
          check("overlap", was, BURST && acnt > 0);
          check("hwrite", ahb.HWRITE, p_write);
          check("hsize_lock_prot", {ahb.HSIZE, ahb.HMASTLOCK, ahb.HPROT}, {HSIZE_WORD, 1'b0, 4'b0011});
          dp = 1;
          dbeat = acnt;
          acnt++;
          dp_wait = p_wait[dbeat];
          dp_err_stage = 0;
        end
      end
    end
  end
  task automatic run();
    int n, sum;
    logic [127:0] exp;
    sum = 0;
    exp = '0;
    for (int k = 0; k < 4; k++) begin
      sum += p_wait[k];
      if (p_err < 0 || k < p_err) exp[32*k +: 32] = p_rd[k];
    end
    acnt = 0;
    killed = 0;
    @(negedge HCLK);
    mem_req = 1'b1;
    mem_write = p_write;
    mem_addr = p_line;
    mem_wdata = p_wdata;
    n = 0;
    do begin
      @(negedge HCLK);
      #2;
      n++;
    end while (!mem_valid && n < 100);
    check("valid_timeout", n < 100, 1);
    if (p_err < 0) check("latency", n - 1, (BURST ? 5 : 8) + sum);
    check("mem_error", mem_error, p_err >= 0);
    if (!p_write) check("mem_rdata", mem_rdata, exp);
    check("beat_count", acnt, p_err < 0 ? 4 : p_err + 1);
    mem_req = 1'b0;
    @(negedge HCLK);
    #2;
    check("valid_pulse", mem_valid, 0);
  endtask
  task automatic plan(input logic [15:0] line, input bit wr, input int err);
    p_line = line;
    p_write = wr;
    p_err = err;
    p_wdata = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      p_rd[k] = $urandom;
      p_wait[k] = 0;
    end
  endtask
  initial begin
    plan(16'h0, 0, -1);
    #12;
    check("rst_htrans", ahb.HTRANS, HTRANS_IDLE);
    check("rst_haddr", ahb.HADDR, 0);
    check("rst_hwrite", ahb.HWRITE, 0);
    check("rst_hwdata", ahb.HWDATA, 0);
    check("rst_hburst", ahb.HBURST, HBURST_SINGLE);
    check("rst_valid_err", {mem_valid, mem_error}, 0);
    check("rst_rdata", mem_rdata, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    plan(16'h0500, 0, -1);
    p_rd = '{32'h11, 32'h22, 32'h33, 32'h44};
    run();
    check("t1_rdata_literal", mem_rdata, 128'h00000044_00000033_00000022_00000011);
    plan(16'h0123, 1, -1);
    p_wdata = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    run();
    plan(16'h0042, 0, -1);
    p_wait[2] = 2;
    run();
    plan(16'h0077, 0, 1);
    run();
    plan(16'h0003, 0, -1);
    @(negedge HCLK);
    acnt = 0;
    killed = 0;
    mem_req = 1'b1;
    mem_write = 1'b0;
    mem_addr = p_line;
    repeat (3) @(negedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    check("abort_htrans", ahb.HTRANS, HTRANS_IDLE);
    check("abort_haddr", ahb.HADDR, 0);
    mem_req = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      #2;
      check("abort_no_valid", mem_valid, 0);
    end
    HRESETn = 1'b1;
    plan(16'h0009, 0, -1);
    run();
    plan(16'h0000, 0, -1);
    run();
    plan(16'hFFFF, 1, -1);
    run();
    plan(16'hFFFF, 0, 3);
    run();
    for (int t = 0; t < 40; t++) begin
      plan(16'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1);
      for (int k = 0; k < 4; k++) p_wait[k] = int'($urandom_range(0, 2));
      run();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
